bootdata_sender: RTL and testbench
==================================

// Module: bootdata_sender
// PURPOSE
//  Control-module-side transmitter for the CPC ROM boot path. Pulls a ROM image as a
//  byte stream (SD/flash reader), packs 4 bytes per 32-bit word and hands each word to
//  the memory-side bootloader over the host_bootdata / req / ack handshake. Flags
//  completion once ROM_BYTES bytes are delivered, so the core can be released from reset.
// PARAMETERS
//  ROM_BYTES    16384  image length in bytes, 1..65535; non-multiple of 4 is padded
//  ACK_TIMEOUT  65535  clk cycles allowed between req rise and ack before error; 0 = never
// PORTS
//  clk                input   1   system clock
//  reset_n            input   1   synchronous, active-low reset
//  start              input   1   1-cycle pulse: begin transfer (ignored unless IDLE/DONE/ERR)
//  src_data           input   8   next image byte
//  src_valid          input   1   src_data valid
//  src_ready          output  1   byte consumed on clk edge where src_valid & src_ready
//  host_bootdata      output  32  packed word, first byte of the group in [31:24]
//  host_bootdata_req  output  1   word on host_bootdata valid, held until ack
//  host_bootdata_ack  input   1   receiver consumed word (sampled synchronously)
//  busy               output  1   transfer in progress
//  done               output  1   all ROM_BYTES delivered; held until start or reset
//  error              output  1   ack timeout; held until start or reset
//  bytes_sent         output  16  count of bytes acked by receiver (padding excluded)
// BEHAVIOUR
//  Reset: state IDLE; src_ready=0, host_bootdata=0, req=0, busy=0, done=0, error=0,
//   bytes_sent=0, internal byte counter/lane index/timeout counter =0.
//  States: IDLE -> FILL on start (clears done/error/bytes_sent, busy=1).
//   FILL: src_ready=1; each accepted byte shifts into lane (lane0 -> [31:24] ... lane3 ->
//    [7:0]); lane index and byte counter increment. Word complete when 4 bytes taken or
//    byte counter reaches ROM_BYTES (remaining lanes = 8'h00). On the completing edge:
//    src_ready drops, host_bootdata loads, req=1 next cycle, -> REQ. Zero bubbles in FILL.
//   REQ: req=1, host_bootdata stable, src_ready=0. On ack=1: req=0 next edge, bytes_sent
//    += bytes in word (4, or remainder for final word); -> FILL if bytes remain, else DONE.
//    Min one cycle req=0 between words (ack held high must not double-count).
//   DONE: busy=0, done=1, req=0. start -> FILL (re-send from byte 0).
//   ERR: entered when timeout counter reaches ACK_TIMEOUT in REQ (ACK_TIMEOUT!=0);
//    req=0, busy=0, error=1. start -> FILL.
//  Timeout counter clears on entering REQ, counts each REQ cycle without ack.
//  ack outside REQ ignored. start during FILL/REQ ignored. src_valid with src_ready=0:
//   byte not consumed (no loss, no duplication).
//  Latency: last byte of a word accepted at edge N -> req=1 from edge N (visible cycle N+1);
//   ack sampled at edge M -> req=0 after M, next FILL begins cycle M+1.
//  bytes_sent saturates at ROM_BYTES; width 16 bit, no wrap.
//  reset_n=0 mid-transfer: immediate return to reset values next edge; no partial word
//   left on req; receiver sees req fall.
// TESTING
//  1. ROM_BYTES=8, bytes 01..08, ack 1 cycle after req -> words 0x01020304,0x05060708;
//     done=1, bytes_sent=8, src_ready low while req high.
//  2. ROM_BYTES=6, bytes AA..AF -> second word 0xAEAF0000; bytes_sent=6; done=1.
//  3. ack held high 5 cycles per word -> each word counted once; req low >=1 cycle between.
//  4. ACK_TIMEOUT=10, ack never asserted -> error=1 at 10th REQ cycle, req=0, busy=0;
//     start -> restart from byte 0, error cleared.
//  5. src_valid toggling 1/0 randomly, ROM_BYTES=16384 -> byte-exact image on receiver
//     model, 4096 words, done=1, bytes_sent=16384.
//  6. reset_n=0 while req=1 on word 3 -> next cycle all outputs at reset values; start
//     afterwards resends from byte 0.

Source files
------------

// File: rtl/bootdata_sender.sv
// ----------------------------------------------------------------------------
// bootdata_sender
//
// Control-side transmitter for the ROM boot path. Bytes of the ROM image are
// pulled from a byte source and packed four to a 32-bit word, first byte in
// [31:24]. Each word is offered to the memory-side bootloader on a req/ack
// handshake. When ROM_BYTES bytes have been acknowledged, done is raised so
// the core can leave reset. A final partial word is padded with 8'h00.
//
// Parameters
//   ROM_BYTES    image length in bytes (1..65535)
//   ACK_TIMEOUT  cycles req may wait for ack before error; 0 disables
//
// Ports
//   clk                input   system clock
//   reset_n            input   synchronous, active-low reset
//   start              input   1-cycle pulse, begins a transfer from byte 0
//   src_data[7:0]      input   next image byte
//   src_valid          input   src_data valid
//   src_ready          output  byte consumed on edge with src_valid & src_ready
//   host_bootdata[31:0] output packed word, held while req is high
//   host_bootdata_req  output  word valid, held until ack
//   host_bootdata_ack  input   receiver consumed the word
//   busy               output  transfer in progress
//   done               output  whole image delivered (held until start/reset)
//   error              output  ack timeout (held until start/reset)
//   bytes_sent[15:0]   output  bytes acknowledged by receiver, padding excluded
// ----------------------------------------------------------------------------
module bootdata_sender #(
    parameter int ROM_BYTES   = 16384,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] bytes_sent
);

    localparam logic [16:0] ROM_LEN = 17'(ROM_BYTES);
    localparam logic [16:0] TMO_LIM = 17'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_byte_cnt,   w_byte_cnt_next;    // image bytes taken so far
    logic [1:0]  r_lane,       w_lane_next;        // next lane to fill
    logic [31:0] r_word,       w_word_next;        // word under assembly
    logic [31:0] r_bootdata,   w_bootdata_next;    // word presented to receiver
    logic [15:0] r_tmo_cnt,    w_tmo_cnt_next;     // REQ cycles without ack
    logic [15:0] r_bytes_sent, w_bytes_sent_next;
    logic [2:0]  r_word_bytes, w_word_bytes_next;  // real (unpadded) bytes in word

    logic [31:0] w_filled;
    logic [16:0] w_sent_sum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_lane       <= '0;
            r_word       <= '0;
            r_bootdata   <= '0;
            r_tmo_cnt    <= '0;
            r_bytes_sent <= '0;
            r_word_bytes <= '0;
        end else begin
            r_state      <= w_state_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_lane       <= w_lane_next;
            r_word       <= w_word_next;
            r_bootdata   <= w_bootdata_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_bytes_sent <= w_bytes_sent_next;
            r_word_bytes <= w_word_bytes_next;
        end
    end

    // Current word with the incoming byte dropped into its lane.
    always_comb begin
        w_filled = r_word;
        case (r_lane)
            2'd0:    w_filled[31:24] = src_data;
            2'd1:    w_filled[23:16] = src_data;
            2'd2:    w_filled[15:8]  = src_data;
            default: w_filled[7:0]   = src_data;
        endcase
    end

    // Saturating add so bytes_sent can never pass the image length.
    always_comb begin
        w_sent_sum = {1'b0, r_bytes_sent} + {14'd0, r_word_bytes};
        if (w_sent_sum > ROM_LEN) begin
            w_sent_sum = ROM_LEN;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_byte_cnt_next   = r_byte_cnt;
        w_lane_next       = r_lane;
        w_word_next       = r_word;
        w_bootdata_next   = r_bootdata;
        w_tmo_cnt_next    = r_tmo_cnt;
        w_bytes_sent_next = r_bytes_sent;
        w_word_bytes_next = r_word_bytes;

        src_ready         = 1'b0;
        host_bootdata_req = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        error             = 1'b0;

        case (r_state)
            S_FILL: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (src_valid) begin
                    w_byte_cnt_next   = r_byte_cnt + 16'd1;
                    w_lane_next       = r_lane + 2'd1;
                    w_word_bytes_next = r_word_bytes + 3'd1;
                    // Word closes on the 4th lane or on the last image byte;
                    // untouched lanes are still zero, which is the padding.
                    if (r_lane == 2'd3 || ({1'b0, r_byte_cnt} + 17'd1) == ROM_LEN) begin
                        w_bootdata_next = w_filled;
                        w_word_next     = '0;
                        w_lane_next     = '0;
                        w_tmo_cnt_next  = '0;
                        w_state_next    = S_REQ;
                    end else begin
                        w_word_next = w_filled;
                    end
                end
            end
            S_REQ: begin
                host_bootdata_req = 1'b1;
                busy              = 1'b1;
                if (host_bootdata_ack) begin
                    w_bytes_sent_next = w_sent_sum[15:0];
                    w_word_bytes_next = '0;
                    // Leaving REQ for at least one FILL cycle guarantees req
                    // drops between words even if ack is held high.
                    w_state_next = ({1'b0, r_byte_cnt} == ROM_LEN) ? S_DONE : S_FILL;
                end else if (TMO_LIM != 17'd0) begin
                    if (({1'b0, r_tmo_cnt} + 17'd1) == TMO_LIM) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + 16'd1;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERR all restart from byte 0 on start.
                done  = (r_state == S_DONE);
                error = (r_state == S_ERR);
                if (start) begin
                    w_state_next      = S_FILL;
                    w_byte_cnt_next   = '0;
                    w_lane_next       = '0;
                    w_word_next       = '0;
                    w_tmo_cnt_next    = '0;
                    w_bytes_sent_next = '0;
                    w_word_bytes_next = '0;
                end
            end
        endcase
    end

    assign host_bootdata = r_bootdata;
    assign bytes_sent    = r_bytes_sent;

endmodule

// File: tb/tb_bootdata_sender.sv
// ----------------------------------------------------------------------------
// tb_bootdata_sender
//
// Three sender instances share clock, reset, byte source and ack; each has
// its own start, so only the unit under test ever leaves IDLE.
//   unit 0: ROM_BYTES=8, unit 1: ROM_BYTES=6, unit 2: ROM_BYTES=16384 with
//   ACK_TIMEOUT=10.
// The receiver model rebuilds every word from the image array and the number
// of words acknowledged, independent of how the sender packs them.
// ----------------------------------------------------------------------------
module tb_bootdata_sender;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  start;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        ack;

    logic        src_ready [3];
    logic [31:0] bd        [3];
    logic        req       [3];
    logic        busy      [3];
    logic        done      [3];
    logic        error     [3];
    logic [15:0] bs        [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] img [0:16383];

    int words_rx_g;
    int req_high_g;
    int idx_g;

    always #5 clk = ~clk;

    bootdata_sender #(.ROM_BYTES(8), .ACK_TIMEOUT(65535)) u_rom8 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready[0]),
        .host_bootdata(bd[0]), .host_bootdata_req(req[0]), .host_bootdata_ack(ack),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .bytes_sent(bs[0])
    );

    bootdata_sender #(.ROM_BYTES(6), .ACK_TIMEOUT(65535)) u_rom6 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready[1]),
        .host_bootdata(bd[1]), .host_bootdata_req(req[1]), .host_bootdata_ack(ack),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .bytes_sent(bs[1])
    );

    bootdata_sender #(.ROM_BYTES(16384), .ACK_TIMEOUT(10)) u_rom16k (
        .clk(clk), .reset_n(reset_n), .start(start[2]),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready[2]),
        .host_bootdata(bd[2]), .host_bootdata_req(req[2]), .host_bootdata_ack(ack),
        .busy(busy[2]), .done(done[2]), .error(error[2]), .bytes_sent(bs[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input int u);
        chk($sformatf("rst_src_ready[%0d]", u), 32'(src_ready[u]), 32'd0);
        chk($sformatf("rst_bootdata[%0d]", u),  bd[u],              32'd0);
        chk($sformatf("rst_req[%0d]", u),       32'(req[u]),        32'd0);
        chk($sformatf("rst_busy[%0d]", u),      32'(busy[u]),       32'd0);
        chk($sformatf("rst_done[%0d]", u),      32'(done[u]),       32'd0);
        chk($sformatf("rst_error[%0d]", u),     32'(error[u]),      32'd0);
        chk($sformatf("rst_bytes_sent[%0d]", u), 32'(bs[u]),        32'd0);
    endtask

    // Pulse start on unit u, then stream the image until done, error, or
    // (stop_words > 0) the moment req rises on word number stop_words.
    // delay < 0 picks a random ack delay of 0..3 cycles per word.
    task automatic run_xfer(input int u, input int rom, input int valid_pct,
                            input int delay, input int hold, input int stop_words);
        int          idx = 0, words = 0, acked = 0, wait_cnt = 0, hold_left = 0;
        int          cur_delay = 0, req_cyc = 0, cyc = 0, exp_sent;
        bit          prev_v = 0, prev_rdy = 0, prev_ack = 0, prev_req = 0;
        bit          acked_word = 0, fin = 0;
        logic [31:0] cur = '0, expw;

        ack = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        chk("start_busy", 32'(busy[u]), 32'd1);
        chk("start_done", 32'(done[u]), 32'd0);
        chk("start_error", 32'(error[u]), 32'd0);
        chk("start_bytes_sent", 32'(bs[u]), 32'd0);

        while (!fin) begin
            if (prev_v && prev_rdy) idx++;
            if (prev_ack && prev_req) begin
                acked++;
                exp_sent = (4 * acked < rom) ? 4 * acked : rom;
                chk("req_gap", 32'(req[u]), 32'd0);
                chk("bytes_sent", 32'(bs[u]), 32'(exp_sent));
            end
            if (req[u]) chk("ready_in_req", 32'(src_ready[u]), 32'd0);
            if (req[u] && !prev_req) begin
                expw = '0;
                for (int k = 0; k < 4; k++) begin
                    if (4 * words + k < rom) expw |= 32'(img[4 * words + k]) << (24 - 8 * k);
                end
                chk($sformatf("word%0d", words), bd[u], expw);
                cur = bd[u];
                words++;
                acked_word = 0;
                wait_cnt = 0;
                req_cyc = 0;
                cur_delay = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                if (words == stop_words) fin = 1;
            end else if (req[u]) begin
                chk("word_hold", bd[u], cur);
            end
            if (req[u]) req_cyc++;
            if (error[u] || done[u]) fin = 1;
            cyc++;
            if (cyc > 60000) begin
                chk("cycle_budget", 32'(done[u] | error[u]), 32'd1);
                fin = 1;
            end

            if (hold_left > 0) hold_left--;
            if (req[u] && !acked_word) begin
                if (wait_cnt >= cur_delay) begin
                    hold_left = hold;
                    acked_word = 1;
                end else begin
                    wait_cnt++;
                end
            end
            ack = (hold_left > 0) && !fin;

            prev_rdy = src_ready[u];
            prev_req = req[u];
            prev_ack = ack;
            src_valid = (idx < rom) && !fin && ($urandom_range(0, 99) < valid_pct);
            src_data = src_valid ? img[idx] : 8'($urandom);
            prev_v = src_valid;
            if (!fin) @(negedge clk);
        end
        src_valid = 1'b0;
        words_rx_g = words;
        req_high_g = req_cyc;
        idx_g = idx;
    endtask

    task automatic chk_done(input int u, input int rom);
        chk("done", 32'(done[u]), 32'd1);
        chk("done_busy", 32'(busy[u]), 32'd0);
        chk("done_req", 32'(req[u]), 32'd0);
        chk("done_error", 32'(error[u]), 32'd0);
        chk("done_src_ready", 32'(src_ready[u]), 32'd0);
        chk("done_bytes_sent", 32'(bs[u]), 32'(rom));
        chk("done_words", 32'(words_rx_g), 32'((rom + 3) / 4));
        chk("done_bytes_taken", 32'(idx_g), 32'(rom));
    endtask

    initial begin
        reset_n = 1'b0;
        start = '0;
        src_valid = 1'b0;
        src_data = '0;
        ack = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk_reset_state(u);
        reset_n = 1'b1;

        // 8-byte image 01..08, ack one cycle after req
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        run_xfer(0, 8, 100, 1, 1, 0);
        chk_done(0, 8);
        $display("xfer rom8 ack+1: words=%0d bytes_sent=%0d", words_rx_g, bs[0]);

        // same image, ack held high for 5 cycles, gappy source
        run_xfer(0, 8, 70, 0, 5, 0);
        chk_done(0, 8);
        $display("xfer rom8 ack-hold5: words=%0d bytes_sent=%0d", words_rx_g, bs[0]);

        // 6-byte image AA..AF, padded final word
        for (int i = 0; i < 6; i++) img[i] = 8'(8'hAA + i);
        run_xfer(1, 6, 100, 1, 1, 0);
        chk_done(1, 6);
        $display("xfer rom6: words=%0d bytes_sent=%0d last=0x%08h", words_rx_g, bs[1], bd[1]);

        // full 16 KiB random image, random src_valid and ack delay
        for (int i = 0; i < 16384; i++) img[i] = 8'($urandom);
        run_xfer(2, 16384, 50, -1, 1, 0);
        chk_done(2, 16384);
        $display("xfer rom16k: words=%0d bytes_sent=%0d", words_rx_g, bs[2]);

        // ack never arrives: error after 10 REQ cycles
        run_xfer(2, 16384, 100, 1 << 30, 1, 0);
        chk("tmo_error", 32'(error[2]), 32'd1);
        chk("tmo_req", 32'(req[2]), 32'd0);
        chk("tmo_busy", 32'(busy[2]), 32'd0);
        chk("tmo_done", 32'(done[2]), 32'd0);
        chk("tmo_req_cycles", 32'(req_high_g), 32'd10);
        $display("xfer timeout: req_cycles=%0d error=%0d", req_high_g, error[2]);

        // restart from ERR, stop with req high on word 3, then reset
        run_xfer(2, 16384, 80, -1, 1, 3);
        chk("w3_req", 32'(req[2]), 32'd1);
        chk("w3_words", 32'(words_rx_g), 32'd3);
        $display("xfer restart: stopped on word %0d", words_rx_g);
        reset_n = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) chk_reset_state(u);
        reset_n = 1'b1;
        $display("xfer reset mid-word: req=%0d bytes_sent=%0d", req[2], bs[2]);

        // after reset the image restarts from byte 0
        run_xfer(2, 16384, 100, 0, 1, 1);
        chk("post_reset_words", 32'(words_rx_g), 32'd1);
        $display("xfer post-reset: first word=0x%08h", bd[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
